// File: rtl/frame_sched_pkg.sv
// -----------------------------------------------------------------------------
// frame_sched_pkg
//   Shared definitions for the frame/slot scheduler:
//     - sched_state_e : scheduler FSM states (IDLE, ARB, BUSY, HOLD)
//     - N_REQ_DEF, SLOTS_PER_FRAME_DEF : default configuration
//     - gid_w()       : width of a requester index for a given requester count
// -----------------------------------------------------------------------------
package frame_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // waiting for a frame start
        ST_ARB  = 2'd1,  // one-cycle arbitration after an accepted tick
        ST_BUSY = 2'd2,  // resource granted, waiting for done
        ST_HOLD = 2'd3   // slot finished (or empty), waiting for next tick
    } sched_state_e;

    localparam int N_REQ_DEF           = 4;
    localparam int SLOTS_PER_FRAME_DEF = 10;

    // Width of a requester index; never narrower than one bit.
    function automatic int gid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_arbiter_pick
//   Round-robin selector. Combinationally picks the first asserted request at
//   or after the internal pointer (wrapping). When load is high and a pick is
//   valid, the pointer advances to one past the picked index.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous, active-high reset (pointer -> 0)
//   req      in   [N_REQ-1:0] request vector
//   load     in   commit the current pick (advance pointer)
//   valid    out  at least one request is asserted
//   pick     out  [N_REQ-1:0] one-hot pick (zero when !valid)
//   pick_id  out  [ID_W-1:0]  index of the pick (zero when !valid)
// -----------------------------------------------------------------------------
module rr_arbiter_pick
    import frame_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = gid_w(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             load,
    output logic             valid,
    output logic [N_REQ-1:0] pick,
    output logic [ID_W-1:0]  pick_id
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] idx;

    // Scan N_REQ positions starting at the pointer; the first hit wins.
    // NOTE: every variable driven here gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid   = 1'b0;
        pick_id = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!valid && req[idx]) begin
                valid   = 1'b1;
                pick_id = idx;
            end
        end
    end

    assign pick = valid ? (N_REQ'(1) << pick_id) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (load && valid) begin
            ptr_d = (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + ID_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/frame_slot_scheduler.sv
// -----------------------------------------------------------------------------
// frame_slot_scheduler
//   Time-division scheduler sharing one processing resource among N_REQ
//   requesters. Each frame (tick_frame) is split into SLOTS_PER_FRAME slots
//   (tick_slot); each slot grants at most one requester, chosen round-robin.
//   A tick that arrives while a grant is still outstanding revokes it and
//   records a sticky overrun.
//
//   Optional build macro FRAME_SLOT_WATCHDOG_EN adds a watchdog: if
//   SLOTS_PER_FRAME+2 slot strobes arrive without a frame strobe, tick_lost is
//   set and the scheduler is forced back to IDLE (no overrun recorded).
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   tick_frame   in   frame-start strobe
//   tick_slot    in   slot strobe
//   req          in   [N_REQ-1:0] per-client request (level)
//   done         in   [N_REQ-1:0] completion strobe (only grantee's honoured)
//   clr_err      in   clears overrun (and tick_lost)
//   grant        out  [N_REQ-1:0] one-hot or zero grant
//   grant_id     out  index of current/last grantee
//   slot_idx     out  [SLOT_W-1:0] current slot number
//   frame_start  out  one-cycle pulse per accepted tick_frame
//   tick_lost    out  sticky watchdog flag (FRAME_SLOT_WATCHDOG_EN only)
//   overrun      out  sticky revocation flag
//   overrun_id   out  grantee captured at the most recent overrun
// -----------------------------------------------------------------------------
module frame_slot_scheduler
    import frame_sched_pkg::*;
#(
    parameter int N_REQ           = N_REQ_DEF,
    parameter int SLOTS_PER_FRAME = SLOTS_PER_FRAME_DEF,
    parameter int SLOT_W          = 4,
    localparam int ID_W           = gid_w(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_frame,
    input  logic              tick_slot,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  done,
    input  logic              clr_err,
    output logic [N_REQ-1:0]  grant,
    output logic [ID_W-1:0]   grant_id,
    output logic [SLOT_W-1:0] slot_idx,
    output logic              frame_start,
`ifdef FRAME_SLOT_WATCHDOG_EN
    output logic              tick_lost,
`endif
    output logic              overrun,
    output logic [ID_W-1:0]   overrun_id
);

    sched_state_e      state_q;
    logic [N_REQ-1:0]  grant_q;
    logic [ID_W-1:0]   grant_id_q;
    logic [SLOT_W-1:0] slot_idx_q;
    logic              frame_start_q;
    logic              overrun_q;
    logic [ID_W-1:0]   overrun_id_q;

    logic              arb_valid;
    logic [N_REQ-1:0]  arb_pick;
    logic [ID_W-1:0]   arb_id;

    logic tick_any;      // a tick accepted outside IDLE
    logic grantee_done;  // done strobe from the current grantee
    logic last_slot;
    logic wd_fire;       // watchdog forces IDLE this cycle
    logic arb_load;
    logic overrun_set;

    assign tick_any     = (state_q != ST_IDLE) && (tick_frame || tick_slot);
    assign grantee_done = done[grant_id_q];
    assign last_slot    = (slot_idx_q == SLOT_W'(SLOTS_PER_FRAME - 1));

    // Only a real commit in ARB advances the round-robin pointer; a tick or a
    // watchdog hit during ARB abandons the arbitration.
    assign arb_load     = (state_q == ST_ARB) && !tick_any && !wd_fire;

    // A tick cuts an outstanding grant short unless done arrives in the same
    // cycle; the watchdog recovery is not an overrun.
    assign overrun_set  = tick_any && (state_q == ST_BUSY) && !grantee_done && !wd_fire;

`ifdef FRAME_SLOT_WATCHDOG_EN
    logic [4:0] wd_cnt_q;
    logic       tick_lost_q;

    // Slot strobes coincident with a frame strobe are not counted: the frame wins.
    assign wd_fire = tick_slot && !tick_frame && (wd_cnt_q == 5'(SLOTS_PER_FRAME + 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q    <= '0;
            tick_lost_q <= 1'b0;
        end else begin
            if (tick_frame) begin
                wd_cnt_q <= '0;
            end else if (tick_slot && (wd_cnt_q < 5'(SLOTS_PER_FRAME + 2))) begin
                wd_cnt_q <= wd_cnt_q + 5'd1;
            end
            if (wd_fire)      tick_lost_q <= 1'b1;
            else if (clr_err) tick_lost_q <= 1'b0;
        end
    end

    assign tick_lost = tick_lost_q;
`else
    assign wd_fire = 1'b0;
`endif

    rr_arbiter_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .load    (arb_load),
        .valid   (arb_valid),
        .pick    (arb_pick),
        .pick_id (arb_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            slot_idx_q    <= '0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_id_q  <= '0;
        end else begin
            frame_start_q <= 1'b0;

            if (wd_fire) begin
                state_q <= ST_IDLE;
                grant_q <= '0;
            end else if (tick_any) begin
                // Any accepted tick ends the current slot's grant.
                grant_q <= '0;
                if (tick_frame) begin
                    slot_idx_q    <= '0;
                    frame_start_q <= 1'b1;
                    state_q       <= ST_ARB;
                end else if (!last_slot) begin
                    slot_idx_q <= slot_idx_q + SLOT_W'(1);
                    state_q    <= ST_ARB;
                end else begin
                    // Slot strobe past the last slot: wait for a new frame.
                    state_q <= ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (tick_frame) begin
                            slot_idx_q    <= '0;
                            frame_start_q <= 1'b1;
                            state_q       <= ST_ARB;
                        end
                    end
                    ST_ARB: begin
                        if (arb_valid) begin
                            grant_q    <= arb_pick;
                            grant_id_q <= arb_id;
                            state_q    <= ST_BUSY;
                        end else begin
                            grant_q <= '0;
                            state_q <= ST_HOLD;
                        end
                    end
                    ST_BUSY: begin
                        if (grantee_done) begin
                            grant_q <= '0;
                            state_q <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end

            // Setting wins over a simultaneous clear.
            if (overrun_set) begin
                overrun_q    <= 1'b1;
                overrun_id_q <= grant_id_q;
            end else if (clr_err) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign slot_idx    = slot_idx_q;
    assign frame_start = frame_start_q;
    assign overrun     = overrun_q;
    assign overrun_id  = overrun_id_q;

endmodule

// File: tb/tb_frame_slot_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_slot_scheduler
//   Self-checking bench for frame_slot_scheduler (N_REQ=4, 10 slots/frame).
//   A behavioural model of the slot/grant rules predicts every output after
//   each clock edge; a compare process checks the DUT on each falling edge.
//   Directed scenarios add hand-computed literal expectations, then a long
//   randomized run exercises ticks, requests, done strobes, clears and resets.
// -----------------------------------------------------------------------------
module tb_frame_slot_scheduler;

    localparam int N = 4;
    localparam int S = 10;
`ifdef FRAME_SLOT_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         tick_frame, tick_slot, clr_err;
    logic [N-1:0] req, done;
    logic [N-1:0] grant;
    logic [1:0]   grant_id, overrun_id;
    logic [3:0]   slot_idx;
    logic         frame_start, overrun;
`ifdef FRAME_SLOT_WATCHDOG_EN
    logic         tick_lost;
`endif

    always #5 clk = ~clk;

    frame_slot_scheduler #(
        .N_REQ           (N),
        .SLOTS_PER_FRAME (S),
        .SLOT_W          (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_frame  (tick_frame),
        .tick_slot   (tick_slot),
        .req         (req),
        .done        (done),
        .clr_err     (clr_err),
        .grant       (grant),
        .grant_id    (grant_id),
        .slot_idx    (slot_idx),
        .frame_start (frame_start),
`ifdef FRAME_SLOT_WATCHDOG_EN
        .tick_lost   (tick_lost),
`endif
        .overrun     (overrun),
        .overrun_id  (overrun_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_active;   // inside a frame (not waiting for a frame start)
    bit m_arb;      // an arbitration is due on the next edge
    int m_owner;    // current grantee, -1 when nobody holds the resource
    int m_last;     // last grantee
    int m_slot, m_ptr, m_wd, m_ov_id;
    bit m_fs, m_ov, m_tl;

    task automatic model_step();
        bit fire, set_ov;
        int old_owner;
        if (rst) begin
            m_active = 0; m_arb = 0; m_owner = -1; m_last = 0; m_slot = 0;
            m_fs = 0; m_ov = 0; m_ov_id = 0; m_ptr = 0; m_tl = 0; m_wd = 0;
            return;
        end
        fire      = WD && tick_slot && !tick_frame && (m_wd == S + 1);
        set_ov    = 0;
        old_owner = m_owner;
        m_fs      = 0;
        if (fire) begin
            m_active = 0; m_arb = 0; m_owner = -1;
        end else if (!m_active) begin
            if (tick_frame) begin
                m_slot = 0; m_fs = 1; m_active = 1; m_arb = 1;
            end
        end else if (tick_frame || tick_slot) begin
            if (m_owner >= 0 && !done[m_owner]) set_ov = 1;
            m_owner = -1;
            if (tick_frame) begin
                m_slot = 0; m_fs = 1; m_arb = 1;
            end else if (m_slot < S - 1) begin
                m_slot++; m_arb = 1;
            end else begin
                m_active = 0; m_arb = 0;
            end
        end else if (m_arb) begin
            m_arb = 0;
            for (int k = 0; k < N; k++) begin
                int nx;
                nx = (m_ptr + k) % N;
                if (m_owner < 0 && req[nx]) m_owner = nx;
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_ptr  = (m_owner + 1) % N;
            end
        end else if (m_owner >= 0 && done[m_owner]) begin
            m_owner = -1;
        end
        if (set_ov) begin
            m_ov = 1; m_ov_id = old_owner;
        end else if (clr_err) begin
            m_ov = 0;
        end
        if (fire)         m_tl = 1;
        else if (clr_err) m_tl = 0;
        if (tick_frame)                  m_wd = 0;
        else if (tick_slot && m_wd < S + 2) m_wd++;
    endtask

    task automatic compare();
        check("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("grant_id", 32'(grant_id), 32'(m_last));
        check("slot_idx", 32'(slot_idx), 32'(m_slot));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("overrun", 32'(overrun), 32'(m_ov));
        check("overrun_id", 32'(overrun_id), 32'(m_ov_id));
`ifdef FRAME_SLOT_WATCHDOG_EN
        check("tick_lost", 32'(tick_lost), 32'(m_tl));
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare();
        end
    end

    // ---------------- stimulus ----------------
    // One clock edge; single-cycle strobes are released afterwards.
    task automatic cyc();
        @(posedge clk);
        #1;
        tick_frame = 0; tick_slot = 0; done = '0; clr_err = 0;
    endtask

    // One 10-cycle slot: tick, arbitration, optional done 5 cycles after grant.
    task automatic run_slot(input bit tf, input bit ts, input int exp_id, input bit give_done);
        tick_frame = tf; tick_slot = ts;
        cyc();
        if (tf) begin
            check("lit_frame_start", 32'(frame_start), 32'd1);
            check("lit_slot0", 32'(slot_idx), 32'd0);
        end
        cyc();
        if (exp_id >= 0) begin
            check("lit_grant_id", 32'(grant_id), 32'(exp_id));
            check("lit_grant", 32'(grant), 32'd1 << exp_id);
        end else begin
            check("lit_grant_none", 32'(grant), 32'd0);
        end
        repeat (4) cyc();
        if (give_done && exp_id >= 0) done = N'(1 << exp_id);
        cyc();
        repeat (3) cyc();
    endtask

    int seq[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};

    initial begin
        rst = 1; tick_frame = 1; tick_slot = 0; clr_err = 0; req = '0; done = '0;

        // Reset dominates a coincident frame tick.
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_slot", 32'(slot_idx), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_overrun_id", 32'(overrun_id), 32'd0);
        rst = 0;

        // Full frame, all clients requesting and completing on time.
        req = 4'b1111;
        run_slot(1, 0, seq[0], 1);
        for (int i = 1; i < S; i++) run_slot(0, 1, seq[i], 1);
        check("lit_no_overrun", 32'(overrun), 32'd0);

        // Sparse requests; round-robin skips idle clients, empty slot grants none.
        req = 4'b0101;
        run_slot(1, 0, 2, 1);
        run_slot(0, 1, 0, 1);
        run_slot(0, 1, 2, 1);
        req = 4'b0000;
        run_slot(0, 1, -1, 0);

        // Grantee 3 never completes: the next slot tick revokes it.
        req = 4'b1000;
        run_slot(0, 1, 3, 0);
        tick_slot = 1;
        cyc();
        check("lit_revoke_grant", 32'(grant), 32'd0);
        check("lit_overrun", 32'(overrun), 32'd1);
        check("lit_overrun_id", 32'(overrun_id), 32'd3);
        cyc();
        check("lit_regrant", 32'(grant), 32'h8);
        done = 4'b1000;
        cyc();
        clr_err = 1;
        cyc();
        check("lit_clr_overrun", 32'(overrun), 32'd0);

        // Frame and slot ticks together with done from the grantee.
        req = 4'b0010;
        run_slot(0, 1, 1, 0);
        check("lit_slot6", 32'(slot_idx), 32'd6);
        tick_frame = 1; tick_slot = 1; done = 4'b0010;
        cyc();
        check("lit_coinc_slot", 32'(slot_idx), 32'd0);
        check("lit_coinc_fs", 32'(frame_start), 32'd1);
        check("lit_coinc_grant", 32'(grant), 32'd0);
        check("lit_coinc_no_ovr", 32'(overrun), 32'd0);
        cyc();
        done = 4'b0010;
        cyc();

        // Twelve slot strobes with no frame strobe.
        req = 4'b1111;
        repeat (12) begin
            tick_slot = 1;
            cyc(); cyc(); cyc();
        end
        check("lit_lost_grant", 32'(grant), 32'd0);
`ifdef FRAME_SLOT_WATCHDOG_EN
        check("lit_tick_lost", 32'(tick_lost), 32'd1);
`endif
        tick_frame = 1;
        cyc();
        check("lit_resume_slot", 32'(slot_idx), 32'd0);
        check("lit_resume_fs", 32'(frame_start), 32'd1);
`ifdef FRAME_SLOT_WATCHDOG_EN
        clr_err = 1;
        cyc();
        check("lit_clr_tick_lost", 32'(tick_lost), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 3) req = N'($urandom);
            tick_slot  = ($urandom_range(0, 6) == 0);
            tick_frame = ($urandom_range(0, 49) == 0);
            done       = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            clr_err    = ($urandom_range(0, 39) == 0);
            rst        = ($urandom_range(0, 999) == 0);
            cyc();
        end
        rst = 0;
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
